tb_axis_inc_checker: RTL and testbench
======================================

// Module: tb_axis_inc_checker
// PURPOSE
//   AXI-stream slave that consumes an incrementing-byte stream and checks it.
//   Kept bytes (tkeep=1) must form the sequence 00,01,...,FF,00,... across beats in byte-lane order.
//   Drives pseudo-random tready backpressure and reports byte, packet and error counts.
//   Catches master handshake violations. Synthesizable; sits at the far end of a DUT under test.
// PARAMETERS
//   BYTE_WIDTH    4        data width in bytes; tdata is 8*BYTE_WIDTH bits
//   RANDOM_READY  1        1: LFSR-driven tready; 0: tready=1 whenever not in reset
//   LFSR_SEED     16'hACE1 nonzero reset value of the 16-bit backpressure LFSR
// PORTS
//   clk        in   1             clock
//   rst        in   1             synchronous active-high reset
//   i_tready   out  1             slave ready (registered)
//   i_tvalid   in   1             master valid
//   i_tdata    in   8*BYTE_WIDTH  data; lane i = i_tdata[8*i +: 8]
//   i_tkeep    in   BYTE_WIDTH    per-lane byte qualifier
//   i_tlast    in   1             end of packet
//   byte_cnt   out  32            kept bytes accepted; wraps mod 2^32
//   pkt_cnt    out  32            tlast beats accepted; wraps mod 2^32
//   err_cnt    out  16            mismatching bytes; saturates at 16'hFFFF
//   err        out  1             sticky: err_cnt has ever become nonzero
//   proto_err  out  1             sticky: AXI-stream stability violation seen
// BEHAVIOUR
//   Reset (clk edge with rst=1): all outputs 0, expected byte exp=8'h00, lfsr=LFSR_SEED, stall flag 0.
//   LFSR: Fibonacci, taps 16,14,13,11. Advances every non-reset cycle.
//   i_tready <= RANDOM_READY ? (lfsr[1:0]!=0) : 1. About 75% duty when random.
//   Handshake: a beat is accepted on a cycle where i_tvalid & i_tready. Nothing else updates the counters.
//   Beat check, lanes i=0..BYTE_WIDTH-1 in ascending order; only lanes with i_tkeep[i]=1 are checked:
//     - lane byte == exp: exp <= exp+1 (mod 256).
//     - lane byte != exp: err_cnt+1 (saturating), err <= 1, then resync exp <= lane byte + 1.
//       Result: one error per discontinuity, not one per following byte.
//     - Multiple lanes in one beat chain combinationally, so exp advances by popcount(keep).
//   byte_cnt += popcount(i_tkeep) on each accepted beat.
//   pkt_cnt += 1 on each accepted beat with i_tlast=1, including keep=0 beats.
//   keep=0 beats are legal: no byte or exp change.
//   Output latency: all counters and flags are registered and reflect a beat the cycle after its handshake.
//   Protocol check:
//     - If i_tvalid & ~i_tready, capture {tdata,tkeep,tlast} and set stall=1.
//     - On the next cycle with stall=1, proto_err <= 1 if i_tvalid=0 or the captured fields differ.
//     - stall clears on the handshake.
//   proto_err does not block data checking.
//   Reset mid-stream: counters and exp return to 0 on the same edge. A beat presented during rst is not accepted.
//   Wrap: exp FF->00 is not an error. byte_cnt/pkt_cnt wrap silently. err_cnt holds at FFFF.
// TESTING
//   1 RANDOM_READY=0; beats 32'h03020100 keep F, then 32'h07060504 keep F tlast=1
//     -> byte_cnt=8, pkt_cnt=1, err=0.
//   2 After reset, keep=4'b0101, lanes0/2 = 00/01
//     -> byte_cnt=2, no error; next beat lane0=02 passes.
//   3 With exp=02, send keep=1 lane0=05, then lane0=06
//     -> err_cnt=1, err=1 after first beat; no increment on second.
//   4 RANDOM_READY=1; hold i_tvalid through a cycle with i_tready=0 and change tdata next cycle
//     -> proto_err=1, err stays 0.
//   5 Stream 300 bytes, then assert rst 1 cycle mid-beat
//     -> byte_cnt/pkt_cnt/err_cnt=0, i_tready=0 in cycle after reset edge; restart from 00 passes.
//   6 Send 00..FF then 00 (exp wrap), then keep=0 tlast=1
//     -> err=0, byte_cnt=257, pkt_cnt+1 with byte_cnt unchanged.

Source files
------------

// File: rtl/tb_axis_inc_checker.sv
// tb_axis_inc_checker: AXI-stream sink that checks an incrementing byte stream, applies LFSR backpressure and counts bytes, packets and errors.
module tb_axis_inc_checker #(
  parameter int          BYTE_WIDTH   = 4,
  parameter bit          RANDOM_READY = 1'b1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    i_tready,
  input  logic                    i_tvalid,
  input  logic [8*BYTE_WIDTH-1:0] i_tdata,
  input  logic [BYTE_WIDTH-1:0]   i_tkeep,
  input  logic                    i_tlast,
  output logic [31:0]             byte_cnt,
  output logic [31:0]             pkt_cnt,
  output logic [15:0]             err_cnt,
  output logic                    err,
  output logic                    proto_err
);
  localparam int CW = 9 * BYTE_WIDTH + 1;
  logic [7:0]    exp_q, exp_d;
  logic [15:0]   lfsr_q;
  logic          stall_q;
  logic [CW-1:0] cap_q, beat;
  logic [31:0]   nkeep;
  logic [16:0]   nerr, err_sum;
  logic [15:0]   err_d;
  logic          fb, hs;
  assign beat    = {i_tlast, i_tkeep, i_tdata};
  assign fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign hs      = i_tvalid & i_tready;
  assign err_sum = {1'b0, err_cnt} + nerr;
  assign err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  // Every kept lane resyncs exp to its own value + 1, so a mismatch costs one error only.
  always_comb begin
    exp_d = exp_q;
    nkeep = '0;
    nerr  = '0;
    for (int i = 0; i < BYTE_WIDTH; i++) begin
      if (i_tkeep[i]) begin
        nkeep = nkeep + 32'd1;
        nerr  = (i_tdata[8*i +: 8] != exp_d) ? nerr + 17'd1 : nerr;
        exp_d = i_tdata[8*i +: 8] + 8'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      i_tready  <= 1'b0;
      byte_cnt  <= '0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
      err       <= 1'b0;
      proto_err <= 1'b0;
      exp_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      stall_q   <= 1'b0;
      cap_q     <= '0;
    end else begin
      lfsr_q   <= {lfsr_q[14:0], fb};
      i_tready <= RANDOM_READY ? (lfsr_q[1:0] != 2'b00) : 1'b1;
      stall_q  <= i_tvalid & ~i_tready;
      cap_q    <= beat;
      if (stall_q && (!i_tvalid || cap_q != beat)) proto_err <= 1'b1;
      if (hs) begin
        byte_cnt <= byte_cnt + nkeep;
        pkt_cnt  <= i_tlast ? pkt_cnt + 32'd1 : pkt_cnt;
        exp_q    <= exp_d;
        err_cnt  <= err_d;
        err      <= err | (nerr != '0);
      end
    end
  end
endmodule

// File: tb/tb_tb_axis_inc_checker.sv
// tb_tb_axis_inc_checker: scoreboard bench; a fixed-ready instance carries the data vectors, a random-ready one the backpressure and protocol cases.
module tb_tb_axis_inc_checker;
  typedef struct {
    logic [31:0] b;
    logic [31:0] p;
    logic [15:0] e;
    logic        er;
  } exp_t;
  logic        clk = 0, rst = 1;
  logic        d_valid = 0, d_last = 0, r_valid = 0, r_last = 0;
  logic [31:0] d_data = 0, r_data = 0;
  logic [3:0]  d_keep = 0, r_keep = 0;
  logic        d_tready, d_err, d_perr, r_tready, r_err, r_perr;
  logic [31:0] d_bc, d_pc, r_bc, r_pc;
  logic [15:0] d_ec, r_ec;
  exp_t        sb[$];
  int          asserts = 0, fails = 0;
  logic        pend = 0;

  tb_axis_inc_checker #(.BYTE_WIDTH(4), .RANDOM_READY(1'b0), .LFSR_SEED(16'hACE1)) u_det (
    .clk(clk), .rst(rst), .i_tready(d_tready), .i_tvalid(d_valid), .i_tdata(d_data),
    .i_tkeep(d_keep), .i_tlast(d_last), .byte_cnt(d_bc), .pkt_cnt(d_pc),
    .err_cnt(d_ec), .err(d_err), .proto_err(d_perr));

  tb_axis_inc_checker #(.BYTE_WIDTH(4), .RANDOM_READY(1'b1), .LFSR_SEED(16'hACE1)) u_rnd (
    .clk(clk), .rst(rst), .i_tready(r_tready), .i_tvalid(r_valid), .i_tdata(r_data),
    .i_tkeep(r_keep), .i_tlast(r_last), .byte_cnt(r_bc), .pkt_cnt(r_pc),
    .err_cnt(r_ec), .err(r_err), .proto_err(r_perr));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks each accepted beat one cycle after its handshake.
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("byte_cnt", d_bc, e.b);
        chk("pkt_cnt", d_pc, e.p);
        chk("err_cnt", {16'd0, d_ec}, {16'd0, e.e});
        chk("err", {31'd0, d_err}, {31'd0, e.er});
        chk("proto_err_det", {31'd0, d_perr}, 32'd0);
      end
    end
    pend = d_valid & d_tready & ~rst;
  end

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l,
                      input logic [31:0] eb, input logic [31:0] ep, input logic [15:0] ee, input logic eer);
    int   n;
    logic r;
    sb.push_back('{eb, ep, ee, eer});
    d_valid = 1; d_data = d; d_keep = k; d_last = l;
    n = 0;
    do begin
      @(negedge clk);
      r = d_tready;
      step();
      n++;
    end while (!r && n < 50);
    if (!r) begin
      chk("send_timeout", 32'd1, 32'd0);
      void'(sb.pop_back());
    end
    d_valid = 0;
  endtask

  task automatic check_reset_state();
    chk("rst_byte_cnt", d_bc, 0);
    chk("rst_pkt_cnt", d_pc, 0);
    chk("rst_err_cnt", {16'd0, d_ec}, 0);
    chk("rst_err", {31'd0, d_err}, 0);
    chk("rst_tready_det", {31'd0, d_tready}, 0);
    chk("rst_tready_rnd", {31'd0, r_tready}, 0);
    chk("rst_proto_rnd", {31'd0, r_perr}, 0);
  endtask

  task automatic do_reset();
    step();
    rst = 1; d_valid = 0; r_valid = 0;
    step();
    step();
    rst = 0;
    @(negedge clk);
    check_reset_state();
    step();
  endtask

  function automatic logic [31:0] inc_word(input int base);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = 8'(base + j);
    return w;
  endfunction

  initial begin
    int zeros, ones, n;
    // 1: two full beats, second ends the packet
    do_reset();
    send(32'h03020100, 4'hF, 0, 4, 0, 0, 0);
    send(32'h07060504, 4'hF, 1, 8, 1, 0, 0);
    // 2: sparse keep, then continue at 02
    do_reset();
    send(32'hAA01BB00, 4'b0101, 0, 2, 0, 0, 0);
    send(32'h00000002, 4'b0001, 0, 3, 0, 0, 0);
    // 3: exp=02, jump to 05 then continue with 06
    do_reset();
    send(32'h00000100, 4'b0011, 0, 2, 0, 0, 0);
    send(32'h00000005, 4'b0001, 0, 3, 0, 1, 1);
    send(32'h00000006, 4'b0001, 0, 4, 0, 1, 1);
    // 4: random backpressure and a data change while stalled
    do_reset();
    zeros = 0; ones = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (r_tready) ones++; else zeros++;
      step();
    end
    chk("rnd_ready_low_seen", {31'd0, zeros > 0}, 1);
    chk("rnd_ready_high_seen", {31'd0, ones > 0}, 1);
    r_valid = 1; r_keep = 0; r_data = 32'h11111111; r_last = 0;
    n = 0;
    do begin
      @(negedge clk);
      if (!r_tready) break;
      step();
      n++;
    end while (n < 100);
    chk("rnd_stall_found", {31'd0, r_tready}, 0);
    chk("proto_before", {31'd0, r_perr}, 0);
    step();
    r_data = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    chk("proto_err", {31'd0, r_perr}, 1);
    chk("proto_no_data_err", {31'd0, r_err}, 0);
    r_valid = 0;
    // 5: 300 bytes, reset mid-beat, restart from 00
    do_reset();
    for (int k = 0; k < 75; k++)
      send(inc_word(4 * k), 4'hF, (k % 25) == 24, 32'(4 * (k + 1)), 32'((k + 1) / 25), 0, 0);
    d_valid = 1; d_data = inc_word(300); d_keep = 4'hF; rst = 1;
    step();
    rst = 0; d_valid = 0;
    @(negedge clk);
    chk("mid_rst_byte_cnt", d_bc, 0);
    chk("mid_rst_pkt_cnt", d_pc, 0);
    chk("mid_rst_err_cnt", {16'd0, d_ec}, 0);
    chk("mid_rst_tready", {31'd0, d_tready}, 0);
    step();
    send(32'h03020100, 4'hF, 0, 4, 0, 0, 0);
    // 6: 00..FF, wrap to 00, then an empty tlast beat
    do_reset();
    for (int k = 0; k < 64; k++)
      send(inc_word(4 * k), 4'hF, 0, 32'(4 * (k + 1)), 0, 0, 0);
    send(32'h00000000, 4'b0001, 0, 257, 0, 0, 0);
    send(32'hDEADBEEF, 4'b0000, 1, 257, 1, 0, 0);
    repeat (3) step();
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
